// File: rtl/load_wb_align_pkg.sv
// Shared types and constants for the load writeback aligner.
// Size encodings, load metadata layout and datapath widths.
package load_wb_align_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 64;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [1:0]       size;
        logic             sign;
        logic             merge;
        logic [2:0]       off;
    } load_meta_t;

    localparam int META_W = $bits(load_meta_t);

    // Offset must be a multiple of the access size in bytes.
    function automatic logic misaligned(input logic [1:0] size,
                                        input logic [2:0] off);
        logic r;
        unique case (size)
            SZ_B:    r = 1'b0;
            SZ_H:    r = off[0];
            SZ_W:    r = |off[1:0];
            default: r = |off;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/load_meta_fifo.sv
// Synchronous circular FIFO for outstanding load metadata.
// Full/empty/count outputs, no push-through or pop bypass.
module load_meta_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 12,
    parameter int CNTW  = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_push,
    input  logic [W-1:0]    i_data,
    input  logic            i_pop,
    output logic [W-1:0]    o_data,
    output logic            o_full,
    output logic            o_empty,
    output logic [CNTW-1:0] o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]    r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CNTW-1:0] r_count;
    logic            w_push;
    logic            w_pop;

    assign o_full  = (r_count == CNTW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Storage array, written at the tail on an accepted push.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNTW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNTW'(1);
            end
        end
    end

endmodule

// File: rtl/load_wb_align.sv
// Load response writeback aligner: pairs memory beats with queued
// load metadata and produces one registered byte-select regfile write.
module load_wb_align
    import load_wb_align_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNTW  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [REG_W-1:0]  req_rd,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    input  logic              req_merge,
    input  logic [2:0]        req_off,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wena,
    output logic [REG_W-1:0]  waddr,
    output logic [DATA_W-1:0] wdata,
    output logic [7:0]        sel,
    output logic [CNTW-1:0]   count,
    output logic              err_misalign,
    output logic              err_orphan
);

    logic              w_full;
    logic              w_empty;
    logic              w_accept;
    logic              w_mis;
    logic              w_push;
    logic              w_pop;
    load_meta_t        w_req;
    load_meta_t        w_head;
    logic [META_W-1:0] w_head_bits;
    logic [DATA_W-1:0] w_shifted;
    logic [DATA_W-1:0] w_ext;
    logic [DATA_W-1:0] w_data;
    logic [7:0]        w_lanes;
    logic [7:0]        w_sel;

    logic              r_wena;
    logic [REG_W-1:0]  r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic [7:0]        r_sel;
    logic              r_err_mis;
    logic              r_err_orph;

    assign req_ready = !w_full;
    assign w_accept  = req_valid && req_ready;
    assign w_mis     = misaligned(req_size, req_off);
    assign w_push    = w_accept && !w_mis;
    assign w_pop     = mem_rvalid && !w_empty;

    assign w_req.rd    = req_rd;
    assign w_req.size  = req_size;
    assign w_req.sign  = req_sign;
    assign w_req.merge = req_merge;
    assign w_req.off   = req_off;

    load_meta_fifo #(
        .DEPTH (DEPTH),
        .W     (META_W),
        .CNTW  (CNTW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_req),
        .i_pop   (w_pop),
        .o_data  (w_head_bits),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count)
    );

    assign w_head    = load_meta_t'(w_head_bits);
    assign w_shifted = mem_rdata >> {w_head.off, 3'b000};

    // Extract low bytes of the shifted beat and extend them.
    always_comb begin
        w_ext   = w_shifted;
        w_lanes = 8'hFF;
        unique case (w_head.size)
            SZ_B: begin
                w_ext   = {{56{w_head.sign & w_shifted[7]}},
                           w_shifted[7:0]};
                w_lanes = 8'h01;
            end
            SZ_H: begin
                w_ext   = {{48{w_head.sign & w_shifted[15]}},
                           w_shifted[15:0]};
                w_lanes = 8'h03;
            end
            SZ_W: begin
                w_ext   = {{32{w_head.sign & w_shifted[31]}},
                           w_shifted[31:0]};
                w_lanes = 8'h0F;
            end
            default: begin
                w_ext   = w_shifted;
                w_lanes = 8'hFF;
            end
        endcase
    end

    // Merge writes keep the beat in place and enable only its lanes.
    always_comb begin
        w_data = w_head.merge ? mem_rdata : w_ext;
        w_sel  = w_head.merge ? (w_lanes << w_head.off) : 8'hFF;
        if (w_head.rd == '0) begin
            w_sel = 8'h00;
        end
    end

    // Writeback register: one write per popped response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wena     <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_sel      <= '0;
            r_err_mis  <= 1'b0;
            r_err_orph <= 1'b0;
        end else begin
            r_wena     <= w_pop && (w_head.rd != '0);
            r_err_mis  <= w_accept && w_mis;
            r_err_orph <= mem_rvalid && w_empty;
            if (w_pop) begin
                r_waddr <= w_head.rd;
                r_wdata <= w_data;
                r_sel   <= w_sel;
            end
        end
    end

    assign wena         = r_wena;
    assign waddr        = r_waddr;
    assign wdata        = r_wdata;
    assign sel          = r_sel;
    assign err_misalign = r_err_mis;
    assign err_orphan   = r_err_orph;

endmodule

// File: tb/tb_load_wb_align.sv
// Testbench for load_wb_align: directed vector table, multi-cycle
// corner sequences and a randomized run against a byte-level model.
module tb_load_wb_align;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_rd;
    logic [1:0]  req_size;
    logic        req_sign;
    logic        req_merge;
    logic [2:0]  req_off;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        wena;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic [7:0]  sel;
    logic [2:0]  count;
    logic        err_misalign;
    logic        err_orphan;

    int errors = 0;
    int checks = 0;

    load_wb_align #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rd       (req_rd),
        .req_size     (req_size),
        .req_sign     (req_sign),
        .req_merge    (req_merge),
        .req_off      (req_off),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .wena         (wena),
        .waddr        (waddr),
        .wdata        (wdata),
        .sel          (sel),
        .count        (count),
        .err_misalign (err_misalign),
        .err_orphan   (err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  size;
        logic        sign;
        logic        merge;
        logic [2:0]  off;
        logic [4:0]  rd;
        logic [63:0] rdata;
        logic        e_wena;
        logic [63:0] e_wdata;
        logic [7:0]  e_sel;
    } vec_t;

    typedef struct {
        logic [1:0] size;
        logic       sign;
        logic       merge;
        logic [2:0] off;
        logic [4:0] rd;
    } meta_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic [1:0] sz, input logic sg,
                           input logic mg, input logic [2:0] of,
                           input logic [4:0] rd);
        req_size  = sz;
        req_sign  = sg;
        req_merge = mg;
        req_off   = of;
        req_rd    = rd;
    endtask

    // Byte-loop reference of the expected regfile write.
    task automatic ref_load(input meta_t m, input logic [63:0] d,
                            output logic ew, output logic [63:0] ed,
                            output logic [7:0] es);
        int n;
        int o;
        n  = 1 << m.size;
        o  = int'(m.off);
        ed = 64'd0;
        es = 8'd0;
        if (m.merge) begin
            ed = d;
            for (int i = 0; i < n; i++) es[o + i] = 1'b1;
        end else begin
            for (int i = 0; i < n; i++) ed[8*i +: 8] = d[8*(o+i) +: 8];
            if (m.sign && ed[8*n-1]) begin
                for (int i = n; i < 8; i++) ed[8*i +: 8] = 8'hFF;
            end
            es = 8'hFF;
        end
        ew = (m.rd != 5'd0);
        if (!ew) es = 8'h00;
    endtask

    localparam logic [63:0] D0 = 64'h89AB_CDEF_0123_4567;

    vec_t vt[13];
    meta_t mq[$];

    initial begin
        vt[0]  = '{2'd0, 1'b1, 1'b0, 3'd3, 5'd5, 64'h0000_0000_8000_0000,
                   1'b1, 64'hFFFF_FFFF_FFFF_FF80, 8'hFF};
        vt[1]  = '{2'd2, 1'b0, 1'b0, 3'd4, 5'd7, D0,
                   1'b1, 64'h0000_0000_89AB_CDEF, 8'hFF};
        vt[2]  = '{2'd2, 1'b0, 1'b1, 3'd4, 5'd7, D0,
                   1'b1, D0, 8'hF0};
        vt[3]  = '{2'd1, 1'b1, 1'b0, 3'd6, 5'd9, D0,
                   1'b1, 64'hFFFF_FFFF_FFFF_89AB, 8'hFF};
        vt[4]  = '{2'd1, 1'b0, 1'b0, 3'd2, 5'd9, D0,
                   1'b1, 64'h0000_0000_0000_0123, 8'hFF};
        vt[5]  = '{2'd0, 1'b1, 1'b0, 3'd0, 5'd10, D0,
                   1'b1, 64'h0000_0000_0000_0067, 8'hFF};
        vt[6]  = '{2'd2, 1'b1, 1'b0, 3'd0, 5'd11, D0,
                   1'b1, 64'h0000_0000_0123_4567, 8'hFF};
        vt[7]  = '{2'd2, 1'b1, 1'b0, 3'd4, 5'd11, D0,
                   1'b1, 64'hFFFF_FFFF_89AB_CDEF, 8'hFF};
        vt[8]  = '{2'd3, 1'b0, 1'b0, 3'd0, 5'd31, D0,
                   1'b1, D0, 8'hFF};
        vt[9]  = '{2'd0, 1'b1, 1'b1, 3'd5, 5'd12, D0,
                   1'b1, D0, 8'h20};
        vt[10] = '{2'd1, 1'b0, 1'b1, 3'd6, 5'd13, D0,
                   1'b1, D0, 8'hC0};
        vt[11] = '{2'd0, 1'b0, 1'b0, 3'd7, 5'd3, D0,
                   1'b1, 64'h0000_0000_0000_0089, 8'hFF};
        vt[12] = '{2'd3, 1'b1, 1'b0, 3'd0, 5'd0, D0,
                   1'b0, D0, 8'h00};

        rst        = 1'b1;
        req_valid  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        set_req(2'd0, 1'b0, 1'b0, 3'd0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_wena", 64'(wena), 64'd0);
        chk("rst_waddr", 64'(waddr), 64'd0);
        chk("rst_wdata", wdata, 64'd0);
        chk("rst_sel", 64'(sel), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_errs", 64'({err_misalign, err_orphan}), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd1);

        // Directed single-load vectors.
        for (int i = 0; i < 13; i++) begin
            set_req(vt[i].size, vt[i].sign, vt[i].merge,
                    vt[i].off, vt[i].rd);
            req_valid = 1'b1;
            tick();
            req_valid = 1'b0;
            chk($sformatf("v%0d_cnt1", i), 64'(count), 64'd1);
            mem_rdata  = vt[i].rdata;
            mem_rvalid = 1'b1;
            tick();
            mem_rvalid = 1'b0;
            chk($sformatf("v%0d_wena", i), 64'(wena), 64'(vt[i].e_wena));
            chk($sformatf("v%0d_waddr", i), 64'(waddr), 64'(vt[i].rd));
            chk($sformatf("v%0d_wdata", i), wdata, vt[i].e_wdata);
            chk($sformatf("v%0d_sel", i), 64'(sel), 64'(vt[i].e_sel));
            chk($sformatf("v%0d_cnt0", i), 64'(count), 64'd0);
        end
        tick();
        chk("wena_one_cycle", 64'(wena), 64'd0);

        // Fill the queue and check backpressure.
        for (int i = 1; i <= 4; i++) begin
            set_req(2'd3, 1'b0, 1'b0, 3'd0, 5'(i));
            req_valid = 1'b1;
            tick();
        end
        chk("full_count", 64'(count), 64'd4);
        chk("full_ready", 64'(req_ready), 64'd0);
        set_req(2'd3, 1'b0, 1'b0, 3'd0, 5'd9);
        tick();
        chk("full_reject", 64'(count), 64'd4);
        mem_rdata  = 64'h1111;
        mem_rvalid = 1'b1;
        tick();
        chk("full_pop_noaccept", 64'(count), 64'd3);
        chk("full_wr1", 64'(waddr), 64'd1);
        set_req(2'd3, 1'b0, 1'b0, 3'd0, 5'd5);
        mem_rdata = 64'h2222;
        tick();
        req_valid = 1'b0;
        chk("pushpop_count", 64'(count), 64'd3);
        chk("pushpop_wr2", 64'({wena, waddr}), 64'({1'b1, 5'd2}));
        chk("pushpop_data", wdata, 64'h2222);
        for (int i = 0; i < 3; i++) begin
            mem_rdata = 64'h3333 + 64'(i);
            tick();
            chk($sformatf("order_%0d", i), 64'({wena, waddr}),
                64'({1'b1, (i == 2) ? 5'd5 : 5'(i + 3)}));
            chk($sformatf("order_d%0d", i), wdata, 64'h3333 + 64'(i));
        end
        mem_rvalid = 1'b0;
        chk("drain_count", 64'(count), 64'd0);

        // Misaligned request and orphan response.
        set_req(2'd1, 1'b0, 1'b0, 3'd3, 5'd4);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("mis_pulse", 64'(err_misalign), 64'd1);
        chk("mis_count", 64'(count), 64'd0);
        tick();
        chk("mis_clear", 64'(err_misalign), 64'd0);
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        chk("orph_pulse", 64'(err_orphan), 64'd1);
        chk("orph_wena", 64'(wena), 64'd0);
        tick();
        chk("orph_clear", 64'(err_orphan), 64'd0);

        // Asynchronous reset with loads outstanding and a write pending.
        for (int i = 0; i < 3; i++) begin
            set_req(2'd3, 1'b0, 1'b0, 3'd0, 5'(6 + i));
            req_valid = 1'b1;
            tick();
        end
        req_valid  = 1'b0;
        mem_rdata  = 64'h5555;
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        chk("pre_rst_wena", 64'({wena, waddr}), 64'({1'b1, 5'd6}));
        chk("pre_rst_count", 64'(count), 64'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_wena", 64'(wena), 64'd0);
        chk("arst_wdata", wdata, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        chk("post_rst_orph", 64'(err_orphan), 64'd1);
        chk("post_rst_wena", 64'(wena), 64'd0);
        tick();

        // Randomized traffic against the byte-level model.
        begin
            int issued;
            int cyc;
            int gap;
            int rerr;
            logic rv;
            logic acc;
            logic ew;
            logic [63:0] ed;
            logic [7:0] es;
            meta_t m;
            meta_t h;
            issued = 0;
            cyc    = 0;
            gap    = 0;
            rerr   = 0;
            mq.delete();
            while ((issued < 1000 || mq.size() > 0) && cyc < 20000) begin
                cyc++;
                rv = (mq.size() > 0) && (gap == 0);
                if (rv) gap = $urandom_range(0, 3);
                else if (gap > 0) gap--;
                mem_rvalid = rv;
                mem_rdata  = {$urandom, $urandom};
                req_valid  = 1'b0;
                acc        = 1'b0;
                if (issued < 1000 && $urandom_range(0, 3) != 0) begin
                    m.size  = 2'($urandom_range(0, 3));
                    m.off   = 3'($urandom_range(0, 7)) &
                              ~3'((1 << m.size) - 1);
                    m.sign  = 1'($urandom);
                    m.merge = 1'($urandom_range(0, 3) == 0);
                    m.rd    = 5'($urandom);
                    set_req(m.size, m.sign, m.merge, m.off, m.rd);
                    req_valid = 1'b1;
                    acc = (mq.size() < 4);
                end
                ew = 1'b0;
                ed = '0;
                es = '0;
                h  = '{default: '0};
                if (rv) begin
                    h = mq.pop_front();
                    ref_load(h, mem_rdata, ew, ed, es);
                end
                if (acc) begin
                    mq.push_back(m);
                    issued++;
                end
                tick();
                checks++;
                if (wena !== ew || count !== 3'(mq.size()) || count > 3'd4 ||
                    (rv && (waddr !== h.rd || wdata !== ed || sel !== es))) begin
                    errors++;
                    if (rerr < 10)
                        $display("FAIL rand cyc%0d: got w=%b a=%0d d=%h s=%h c=%0d expected w=%b a=%0d d=%h s=%h c=%0d",
                                 cyc, wena, waddr, wdata, sel, count,
                                 ew, h.rd, ed, es, mq.size());
                    rerr++;
                end
            end
            req_valid  = 1'b0;
            mem_rvalid = 1'b0;
            checks++;
            if (cyc >= 20000) begin
                errors++;
                $display("FAIL rand_timeout: got %0d loads expected 1000", issued);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
